// File: rtl/g_sweep_pkg.sv
// Shared types, sizes and the point-walk helper for the G select sweeper.
// No logic state lives here; the helper is purely combinational.
// The helper applies no backpressure of its own.
package g_sweep_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam int NUM_POINTS = 16;
    localparam int IDX_W      = 4;
    localparam int N_BANK     = 4;
    localparam int N_LANE     = 4;

    // Returns {found, idx} for the lowest point index above cur (or equal to
    // cur when incl is set) whose bank is not masked off.
    function automatic logic [IDX_W:0] next_unmasked_idx(
        input logic [IDX_W-1:0]  cur,
        input logic [N_BANK-1:0] mask,
        input logic              incl
    );
        logic [IDX_W:0]   r;
        logic [IDX_W-1:0] kk;
        r = '0;
        for (int k = NUM_POINTS - 1; k >= 0; k--) begin
            kk = IDX_W'(k);
            if (((kk > cur) || (incl && (kk == cur))) && !mask[kk[IDX_W-1:2]])
                r = {1'b1, kk};
        end
        return r;
    endfunction

endpackage

// File: rtl/g_sweep_timer.sv
// Settle counter: cleared by load, counts while en, flags expiry.
// expire is combinational from the count; it is high on the SETTLE_CYC-th enabled cycle.
// No backpressure; the caller decides when to load and enable.
module g_sweep_timer #(
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CNT_W'(1);
    end

    assign expire = (cnt == CNT_W'(SETTLE_CYC - 1));

endmodule

// File: rtl/g_sel_sweep.sv
// Walks G's bank/lane selects over all unmasked points and samples g217 at each.
// Latency: SETTLE_CYC+1 cycles per unmasked point; result held until res_ready.
// Backpressure: start only accepted in IDLE; DONE holds until res_ready. Macro G_SWEEP_EARLY_EXIT_EN stops on first hit.
module g_sel_sweep
    import g_sweep_pkg::*;
#(
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [3:0]  bank_mask,
    output logic [1:0]  sel_bank,
    output logic [1:0]  sel_lane,
    input  logic        cmp_in,
    output logic        sweep_busy,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_vec,
    output logic [4:0]  hit_cnt,
    output logic [4:0]  first_hit
);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic [N_BANK-1:0]  mask_q, mask_nxt;
    logic [15:0]        vec_nxt;
    logic [4:0]         cnt_nxt, fh_nxt;
    logic [IDX_W:0]     nu_start, nu_step;
    logic               tmr_load, tmr_expire, stop_early;

`ifdef G_SWEEP_EARLY_EXIT_EN
    assign stop_early = cmp_in;
`else
    assign stop_early = 1'b0;
`endif

    assign nu_start = next_unmasked_idx('0, bank_mask, 1'b1);
    assign nu_step  = next_unmasked_idx(idx, mask_q, 1'b0);

    g_sweep_timer #(.SETTLE_CYC(SETTLE_CYC), .CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .en     (state == DRIVE),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        mask_nxt  = mask_q;
        vec_nxt   = res_vec;
        cnt_nxt   = hit_cnt;
        fh_nxt    = first_hit;
        tmr_load  = 1'b0;
        case (state)
            IDLE: begin
                if (start_valid) begin
                    mask_nxt = bank_mask;
                    vec_nxt  = '0;
                    cnt_nxt  = '0;
                    fh_nxt   = '0;
                    if (nu_start[IDX_W]) begin
                        idx_nxt   = nu_start[IDX_W-1:0];
                        tmr_load  = 1'b1;
                        state_nxt = DRIVE;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            DRIVE: begin
                if (tmr_expire)
                    state_nxt = SAMPLE;
            end
            SAMPLE: begin
                vec_nxt[idx] = cmp_in;
                cnt_nxt      = hit_cnt + {4'b0, cmp_in};
                if (cmp_in && !first_hit[4])
                    fh_nxt = {1'b1, idx};
                // Masked banks are skipped within this same edge, costing no cycles.
                if (!stop_early && nu_step[IDX_W]) begin
                    idx_nxt   = nu_step[IDX_W-1:0];
                    tmr_load  = 1'b1;
                    state_nxt = DRIVE;
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (res_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            mask_q    <= '0;
            res_vec   <= '0;
            hit_cnt   <= '0;
            first_hit <= '0;
        end else begin
            idx       <= idx_nxt;
            mask_q    <= mask_nxt;
            res_vec   <= vec_nxt;
            hit_cnt   <= cnt_nxt;
            first_hit <= fh_nxt;
        end
    end

    assign sel_bank    = idx[3:2];
    assign sel_lane    = idx[1:0];
    assign start_ready = (state == IDLE);
    assign sweep_busy  = (state == DRIVE) || (state == SAMPLE);
    assign res_valid   = (state == DONE);

endmodule

// File: doc/g_sel_sweep.md
Name: g_sel_sweep

Overview:
- Sequencer that sits directly upstream of the combinational compare stage G.
- Drives G's two select pairs: bank select g145/g144 and lane select g119/g116.
- Steps through all 16 (bank, lane) points, waits for G to settle, and samples G's single output g217 at each point.
- Returns a 16-bit hit vector, a hit count and the first-hit index to the controller through a valid/ready handshake.

Parameters:
- SETTLE_CYC, 1, cycles a select point is held before sampling; legal range 1..15.
- CNT_W, 4, settle counter width; must hold SETTLE_CYC.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  request a sweep.
- start_ready  out  1  high only in IDLE.
- bank_mask  in  4  captured on start accept; bit b=1 skips bank b.
- sel_bank  out  2  registered; [1]->g145, [0]->g144.
- sel_lane  out  2  registered; [1]->g119, [0]->g116.
- cmp_in  in  1  G output g217.
- sweep_busy  out  1  high in DRIVE or SAMPLE.
- res_valid  out  1  result available (DONE state).
- res_ready  in  1  consumer accepts result.
- res_vec  out  16  bit i = sample at point i = {bank,lane}.
- hit_cnt  out  5  popcount of res_vec (0..16).
- first_hit  out  5  {found, idx[3:0]}; lowest set index.

Behaviour:
- Reset (async, rst_n low) state:
  - state=IDLE; sel_bank=0, sel_lane=0.
  - res_vec=0, hit_cnt=0, first_hit=0.
  - res_valid=0, sweep_busy=0, start_ready=1.
- Reset asserted mid-sweep aborts immediately; no partial result is presented.
- Point index idx: sel_bank=idx[3:2], sel_lane=idx[1:0]. Lane varies fastest.
- IDLE:
  - On start_valid&start_ready: capture bank_mask, clear res_vec/hit_cnt/first_hit.
  - If any bank is unmasked: idx = first unmasked bank's lane 0, go to DRIVE with cnt=0.
  - If all banks are masked: go to DONE next cycle, all results 0.
- DRIVE:
  - Selects are stable; cnt increments each cycle.
  - After SETTLE_CYC cycles in DRIVE, go to SAMPLE.
- SAMPLE (one cycle):
  - On the exiting edge, res_vec[idx]<=cmp_in and hit_cnt+=cmp_in.
  - If cmp_in=1 and found=0, set first_hit={1,idx}.
  - If another unmasked point remains: idx = next unmasked point (masked banks consume zero cycles), go to DRIVE with cnt=0.
  - Otherwise go to DONE.
- DONE:
  - res_valid=1; outputs held stable.
  - On res_ready, go to IDLE; res_valid drops the next cycle.
  - start_valid is ignored until IDLE.
- Cost per unmasked point is SETTLE_CYC+1 cycles.
- Latency from accept edge to res_valid high is U*4*(SETTLE_CYC+1) cycles, U = number of unmasked banks. Full sweep with SETTLE_CYC=1 is 32 cycles.
- Selects stay at the last point while in DONE and IDLE.
- Masked points read 0 in res_vec.
- hit_cnt saturates naturally at 16; width 5 means no wrap.

Optional Feature:
- Macro G_SWEEP_EARLY_EXIT_EN.
- Defined:
  - SAMPLE with cmp_in=1 goes straight to DONE.
  - res_vec holds the single hit bit; hit_cnt is 0 or 1.
  - Latency shortens accordingly.
- Undefined: full sweep as above.

Decomposition:
- Package g_sweep_pkg:
  - state enum {IDLE, DRIVE, SAMPLE, DONE}.
  - NUM_POINTS=16, IDX_W=4, N_BANK=4, N_LANE=4.
  - next_unmasked_idx function.
- Sub-module g_sweep_timer: settle counter with load/expire.

Test Plan:
- Reset mid-DRIVE at idx 5 -> next cycle state IDLE, sel=0, res_valid=0, start_ready=1.
- mask=0000, SETTLE_CYC=1, G model cmp_in=1 only at idx 6 and 13:
  - res_valid 32 cycles after accept.
  - res_vec=16'h2040, hit_cnt=2, first_hit=5'b10110.
- mask=1010, cmp_in=1 everywhere:
  - only idx 0-3 and 8-11 driven.
  - res_vec=16'h0F0F, hit_cnt=8, res_valid after 16 cycles.
- mask=1111 -> res_valid the cycle after accept; res_vec=0, first_hit=0.
- res_ready held low 10 cycles in DONE -> outputs and sel stable; start_valid ignored.
- Early exit with G_SWEEP_EARLY_EXIT_EN, hit at idx 3 -> res_valid after 8 cycles, res_vec=16'h0008, hit_cnt=1.
